// File: rtl/pattern_history_table_if.sv
// Prediction/training port bundle for pattern_history_table.
// master = fetch/resolve side, slave = the table itself.
interface pattern_history_table_if #(
  parameter int INDEX_WIDTH = 5
);
  logic                   ready;
  logic                   pred_valid;
  logic [INDEX_WIDTH-1:0] pred_index;
  logic                   pred_resp_valid;
  logic                   pred_taken;
  logic                   upd_valid;
  logic [INDEX_WIDTH-1:0] upd_index;
  logic                   upd_taken;

  modport master (
    input  ready,
    output pred_valid,
    output pred_index,
    input  pred_resp_valid,
    input  pred_taken,
    output upd_valid,
    output upd_index,
    output upd_taken
  );

  modport slave (
    output ready,
    input  pred_valid,
    input  pred_index,
    output pred_resp_valid,
    output pred_taken,
    input  upd_valid,
    input  upd_index,
    input  upd_taken
  );
endinterface

// File: rtl/pattern_history_table.sv
// Second-level branch predictor: 2-bit saturating counters indexed by local history.
// Optional macro PHT_BYPASS_EN forwards a same-cycle, same-index update into the prediction.
module pattern_history_table #(
  parameter int         INDEX_WIDTH = 5,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic                    clk,
  input  logic                    reset,
  pattern_history_table_if.slave  bus
);
  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] SWEEP_END = (INDEX_WIDTH+1)'(ENTRIES);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  logic [INDEX_WIDTH:0]   sweep;
  logic [1:0]             counters [ENTRIES];
  logic [1:0]             upd_cur;
  logic [1:0]             upd_next;
  logic                   pred_msb;
  logic                   sweep_done;

  assign sweep_done = (sweep == SWEEP_END);

  always_comb begin
    upd_cur  = counters[bus.upd_index];
    upd_next = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
    end

    pred_msb = counters[bus.pred_index][1];
`ifdef PHT_BYPASS_EN
    if (bus.upd_valid && (bus.upd_index == bus.pred_index)) pred_msb = upd_next[1];
`endif
  end

  // sweep counts one past the last entry so the RUN transition lands on the following edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= INIT;
      sweep               <= '0;
      bus.ready           <= 1'b0;
      bus.pred_resp_valid <= 1'b0;
      bus.pred_taken      <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          bus.ready           <= 1'b0;
          bus.pred_resp_valid <= 1'b0;
          if (sweep_done) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        RUN: begin
          bus.ready           <= 1'b1;
          bus.pred_resp_valid <= bus.pred_valid;
          if (bus.pred_valid) bus.pred_taken <= pred_msb;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Counter storage is re-initialised by the sweep, so it carries no reset of its own
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      if (!sweep_done) counters[sweep[INDEX_WIDTH-1:0]] <= CTR_INIT;
    end else if (bus.upd_valid) begin
      counters[bus.upd_index] <= upd_next;
    end
  end
endmodule

// File: tb/tb_pattern_history_table.sv
// Directed and scoreboard-checked bench for pattern_history_table.
module tb_pattern_history_table;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   model [32];
  logic exp_taken;
  int   cycles;

  pattern_history_table_if #(.INDEX_WIDTH(5)) bus ();

  pattern_history_table #(.INDEX_WIDTH(5), .CTR_INIT(2'b01)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of requests, step past the edge, then idle the strobes
  task automatic applyStimulus(input logic pv, input int pi, input logic uv, input int ui, input logic ut);
    bus.pred_valid = pv;
    bus.pred_index = 5'(pi);
    bus.upd_valid  = uv;
    bus.upd_index  = 5'(ui);
    bus.upd_taken  = ut;
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
  endtask

  function automatic int satNext(input int cur, input logic taken);
    if (taken) return (cur >= 3) ? 3 : cur + 1;
    else       return (cur <= 0) ? 0 : cur - 1;
  endfunction

  initial begin
    logic pv, uv, ut;
    int   pi, ui, rd;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.pred_valid = 1'b0;
    bus.pred_index = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_index  = '0;
    bus.upd_taken  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", bus.ready, 0);
    checkOutput("rst_resp", bus.pred_resp_valid, 0);
    checkOutput("rst_taken", bus.pred_taken, 0);
    reset = 1'b0;

    // Sweep: requests are ignored and the update to index 5 must be dropped
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b1, 5, 1'b1, 5, 1'b1);
      checkOutput($sformatf("sweep_ready_%0d", k), bus.ready, 0);
      checkOutput($sformatf("sweep_resp_%0d", k), bus.pred_resp_valid, 0);
    end
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("ready_after_sweep", bus.ready, 1);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, i, 1'b0, 0, 1'b0);
      checkOutput($sformatf("init_resp_%0d", i), bus.pred_resp_valid, 1);
      checkOutput($sformatf("init_taken_%0d", i), bus.pred_taken, 0);
    end

    // Index 7 saturation walk: 01 -> 11, stays 11, down to 00, stays 00
    repeat (3) applyStimulus(1'b0, 0, 1'b1, 7, 1'b1);
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0);
    checkOutput("idx7_after3T", bus.pred_taken, 1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("idle_resp", bus.pred_resp_valid, 0);
    checkOutput("idle_hold", bus.pred_taken, 1);
    applyStimulus(1'b0, 0, 1'b1, 7, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0);
    checkOutput("idx7_sat_hi", bus.pred_taken, 1);
    repeat (2) applyStimulus(1'b0, 0, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0);
    checkOutput("idx7_zero", bus.pred_taken, 0);
    applyStimulus(1'b0, 0, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0);
    checkOutput("idx7_sat_lo", bus.pred_taken, 0);
    applyStimulus(1'b0, 0, 1'b1, 7, 1'b1);
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0);
    checkOutput("idx7_no_wrap", bus.pred_taken, 0);

    // Same-cycle, same-index prediction and update on index 12 (counter 01)
    applyStimulus(1'b1, 12, 1'b1, 12, 1'b1);
    checkOutput("idx12_resp", bus.pred_resp_valid, 1);
`ifdef PHT_BYPASS_EN
    checkOutput("idx12_same_cycle", bus.pred_taken, 1);
`else
    checkOutput("idx12_same_cycle", bus.pred_taken, 0);
`endif
    applyStimulus(1'b1, 12, 1'b0, 0, 1'b0);
    checkOutput("idx12_after", bus.pred_taken, 1);

    // Different indices in the same cycle stay independent
    applyStimulus(1'b1, 20, 1'b1, 21, 1'b1);
    checkOutput("idx20_indep", bus.pred_taken, 0);
    applyStimulus(1'b1, 21, 1'b0, 0, 1'b0);
    checkOutput("idx21_trained", bus.pred_taken, 1);

    // Mid-stream reset after training index 3 to 11
    repeat (2) applyStimulus(1'b0, 0, 1'b1, 3, 1'b1);
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b0);
    checkOutput("idx3_trained", bus.pred_taken, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_ready", bus.ready, 0);
    checkOutput("midrst_resp", bus.pred_resp_valid, 0);
    checkOutput("midrst_taken", bus.pred_taken, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cycles = 0;
    while (!bus.ready && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("resweep_len", cycles, 33);
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b0);
    checkOutput("idx3_reinit", bus.pred_taken, 0);

    // Random traffic against the counter model
    for (int i = 0; i < 32; i++) model[i] = 1;
    exp_taken = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      pv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      ut = 1'($urandom_range(0, 1));
      pi = $urandom_range(0, 31);
      ui = $urandom_range(0, 31);
      if (pv) begin
        rd = model[pi];
`ifdef PHT_BYPASS_EN
        if (uv && ui == pi) rd = satNext(model[ui], ut);
`endif
        exp_taken = (rd >= 2);
      end
      if (uv) model[ui] = satNext(model[ui], ut);
      applyStimulus(pv, pi, uv, ui, ut);
      checkOutput($sformatf("rnd_resp_%0d", n), bus.pred_resp_valid, pv);
      checkOutput($sformatf("rnd_taken_%0d", n), bus.pred_taken, exp_taken);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
